// File: rtl/country_road_controller.sv
// country_road_controller
//   Country-road side of a highway/country-road junction. When the highway
//   controller grants the road (CR_Ena sampled high while idle) the country
//   lamp runs green -> yellow -> all-red clearance, then right-of-way is
//   handed back with a one-cycle HW_Ena pulse.
//
//   Green lasts at least GREEN_MIN and at most GREEN_MAX cycles. Between
//   those bounds it is held for as long as sensor reports a waiting vehicle.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous reset, active high
//   CR_Ena  in   grant from highway controller (honoured only in IDLE)
//   sensor  in   country-road vehicle present
//   CR_LED  out  [2:0] lamp {green,yellow,red}, registered
//   HW_Ena  out  one-cycle hand-back pulse, registered
//   busy    out  high in every state except IDLE, registered
module country_road_controller #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int CLEAR_T   = 1,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CR_Ena,
  input  logic       sensor,
  output logic [2:0] CR_LED,
  output logic       HW_Ena,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, CLEAR} state_t;

  localparam logic [2:0] LED_G = 3'b100;
  localparam logic [2:0] LED_Y = 3'b010;
  localparam logic [2:0] LED_R = 3'b001;

  localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_LOAD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(CLEAR_T - 1);
  // The green timer counts down from GREEN_MAX-1, so the green cycle index
  // is k = GREEN_MAX - timer. k >= GREEN_MIN is therefore timer <= G_EXT.
  localparam logic [CNT_W-1:0] G_EXT  = CNT_W'(GREEN_MAX - GREEN_MIN);

  state_t           state;
  logic [CNT_W-1:0] timer;

  // Outputs are registered together with the state they belong to, so
  // every output changes on the same edge as the state and never depends
  // combinationally on an input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      timer  <= '0;
      CR_LED <= LED_R;
      HW_Ena <= 1'b0;
      busy   <= 1'b0;
    end else begin
      HW_Ena <= 1'b0;
      case (state)
        IDLE: begin
          // Also taken on the HW_Ena cycle: back-to-back grants are legal.
          if (CR_Ena) begin
            state  <= GREEN;
            timer  <= G_LOAD;
            CR_LED <= LED_G;
            busy   <= 1'b1;
          end
        end
        GREEN: begin
          // timer==0 is k==GREEN_MAX: leave regardless of sensor.
          if (timer == '0 || (timer <= G_EXT && !sensor)) begin
            state  <= YELLOW;
            timer  <= Y_LOAD;
            CR_LED <= LED_Y;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        YELLOW: begin
          if (timer == '0) begin
            state  <= CLEAR;
            timer  <= C_LOAD;
            CR_LED <= LED_R;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        CLEAR: begin
          if (timer == '0) begin
            state  <= IDLE;
            HW_Ena <= 1'b1;
            busy   <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          timer  <= '0;
          CR_LED <= LED_R;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_country_road_controller.sv
// Scoreboard bench for country_road_controller. The driver steps a
// reference model of the country-road cycle (green cycle index k, phase
// ages) and queues the outputs expected after each clock edge; a monitor
// pops one entry per falling edge and compares.
module tb_country_road_controller;

  localparam int GMIN = 4;
  localparam int GMAX = 10;
  localparam int YT   = 2;
  localparam int CT   = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       CR_Ena = 1'b0;
  logic       sensor = 1'b0;
  logic [2:0] CR_LED;
  logic       HW_Ena;
  logic       busy;

  country_road_controller #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT), .CLEAR_T(CT), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .CR_Ena(CR_Ena), .sensor(sensor),
    .CR_LED(CR_LED), .HW_Ena(HW_Ena), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] led;
    logic       hw;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_no  = 0;

  // Reference model: phase 0 idle, 1 green, 2 yellow, 3 clear.
  // age = number of cycles already spent in the phase (1 on first cycle).
  int m_phase;
  int m_age;
  bit m_hw;

  function automatic exp_t model_out();
    exp_t e;
    e.led  = (m_phase == 1) ? 3'b100 : (m_phase == 2) ? 3'b010 : 3'b001;
    e.hw   = m_hw;
    e.busy = (m_phase != 0);
    return e;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_age   = 0;
    m_hw    = 0;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input bit cr, input bit sens);
    m_hw = 0;
    case (m_phase)
      0: if (cr) begin m_phase = 1; m_age = 1; end
      1: if (m_age >= GMAX || (m_age >= GMIN && !sens)) begin
           m_phase = 2; m_age = 1;
         end else m_age++;
      2: if (m_age >= YT) begin m_phase = 3; m_age = 1; end else m_age++;
      default: if (m_age >= CT) begin m_phase = 0; m_age = 0; m_hw = 1; end
               else m_age++;
    endcase
  endtask

  // One clock of stimulus: queue what the DUT should show after the edge
  // just taken, then present inputs for the coming edge.
  task automatic cyc(input bit cr, input bit sens);
    @(posedge clk);
    #2;
    exp_q.push_back(model_out());
    rst    = 1'b0;
    CR_Ena = cr;
    sensor = sens;
    model_step(cr, sens);
  endtask

  // Assert reset mid-cycle; its effect must be visible before the next edge.
  task automatic rst_cyc();
    @(posedge clk);
    #2;
    rst    = 1'b1;
    CR_Ena = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
  endtask

  // Monitor: one comparison per falling edge whenever an entry is queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc_no++;
        n_tests++;
        if (CR_LED !== e.led || HW_Ena !== e.hw || busy !== e.busy) begin
          n_fail++;
          $display("FAIL out_cyc%0d: got led=%b hw=%b busy=%b, want led=%b hw=%b busy=%b",
                   cyc_no, CR_LED, HW_Ena, busy, e.led, e.hw, e.busy);
        end
      end
    end
  end

  initial begin
    model_reset();
    // Idle under reset, then 20 quiet cycles.
    rst_cyc();
    rst_cyc();
    repeat (20) cyc(1'b0, 1'b0);

    // Single grant, no vehicle: minimum green.
    cyc(1'b1, 1'b0);
    repeat (12) cyc(1'b0, 1'b0);

    // Vehicle present throughout: green capped at maximum.
    cyc(1'b1, 1'b1);
    repeat (16) cyc(1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0);

    // Vehicle through green cycle 6, gone at cycle 7.
    cyc(1'b1, 1'b1);
    repeat (6) cyc(1'b0, 1'b1);
    repeat (12) cyc(1'b0, 1'b0);

    // Grant re-pulsed during green and yellow, then held high so the
    // hand-back cycle immediately starts a new green.
    cyc(1'b1, 1'b0);
    repeat (6) cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    repeat (20) cyc(1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0);

    // Reset while yellow: immediate abort, no hand-back afterwards.
    cyc(1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0);
    rst_cyc();
    repeat (8) cyc(1'b0, 1'b0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(199) == 0) rst_cyc();
      else cyc($urandom_range(5) == 0, $urandom_range(3) != 0);
    end

    // Drain: final expectation is consumed at the next falling edge.
    @(posedge clk);
    #2;
    exp_q.push_back(model_out());
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/country_road_controller.md
COUNTRY_ROAD_CONTROLLER -- requirements
Module: country_road_controller

Interface
REQ-001 Parameter GREEN_MIN, default 4, minimum country-road green duration in clock cycles (>=1).
REQ-002 Parameter GREEN_MAX, default 10, maximum country-road green duration in clock cycles (>=GREEN_MIN).
REQ-003 Parameter YELLOW_T, default 2, country-road yellow duration in clock cycles (>=1).
REQ-004 Parameter CLEAR_T, default 1, all-red clearance duration in clock cycles before handing back to highway (>=1).
REQ-005 Parameter CNT_W, default 8, internal phase-timer width; SHALL hold GREEN_MAX-1.
REQ-006 clk  input  1  single system clock; all state changes on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 CR_Ena  input  1  grant from highway controller; a high level sampled in IDLE starts a country-road cycle.
REQ-009 sensor  input  1  country-road vehicle present; extends green between GREEN_MIN and GREEN_MAX.
REQ-010 CR_LED  output  3  country-road lamp, encoding {green,yellow,red}: 100 green, 010 yellow, 001 red; registered.
REQ-011 HW_Ena  output  1  one-cycle pulse returning right-of-way to the highway controller; registered.
REQ-012 busy  output  1  high in every state except IDLE; registered.

Function
REQ-013 FSM states SHALL be IDLE, GREEN, YELLOW, CLEAR; all outputs are decoded from registered state, no combinational input-to-output path.
REQ-014 Lamp per state: IDLE 001, GREEN 100, YELLOW 010, CLEAR 001; no other CR_LED value SHALL ever appear.
REQ-015 Phase timer: on entry to a timed state the timer loads duration-1 and decrements by 1 each cycle; it SHALL never wrap below 0.
REQ-016 IDLE -> GREEN on the edge where CR_Ena=1 is sampled; CR_LED=100 from the next cycle (1-cycle latency).
REQ-017 GREEN cycle count k starts at 1 on the first green cycle; at k>=GREEN_MIN with sensor=0 sampled, GREEN -> YELLOW.
REQ-018 GREEN -> YELLOW unconditionally when k=GREEN_MAX, regardless of sensor.
REQ-019 sensor is ignored for k<GREEN_MIN; green never shorter than GREEN_MIN cycles nor longer than GREEN_MAX.
REQ-020 YELLOW lasts exactly YELLOW_T cycles, then -> CLEAR.
REQ-021 CLEAR lasts exactly CLEAR_T cycles, then -> IDLE; HW_Ena=1 for exactly the first IDLE cycle after CLEAR, 0 otherwise.
REQ-022 CR_Ena while busy=1 SHALL be ignored (not queued); CR_Ena held high through a full cycle starts a new cycle only when sampled in IDLE.
REQ-023 CR_Ena=1 in the same IDLE cycle that HW_Ena=1 SHALL start a new cycle (GREEN next).
REQ-024 GREEN_MIN=GREEN_MAX SHALL give fixed green of that length independent of sensor.

Reset
REQ-025 While rst=1: state IDLE, timer 0, CR_LED=001, HW_Ena=0, busy=0, asynchronously.
REQ-026 rst asserted mid-cycle (any state) SHALL abort to IDLE without emitting HW_Ena; after release the block waits for CR_Ena.
REQ-027 First edge after rst deasserts is a normal IDLE evaluation of CR_Ena.

Verification (defaults GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=2, CLEAR_T=1)
REQ-028 Reset, CR_Ena=0 for 20 cycles -> CR_LED=001, busy=0, HW_Ena never 1.
REQ-029 CR_Ena pulse, sensor=0 -> 4 cycles 100, 2 cycles 010, 1 cycle 001 with busy=1, then HW_Ena=1 for 1 cycle, busy=0.
REQ-030 CR_Ena pulse, sensor=1 throughout -> exactly 10 green cycles, then yellow 2, clear 1, HW_Ena pulse.
REQ-031 CR_Ena pulse, sensor=1 until green cycle 6 then 0 -> green 7 cycles (drop sampled at k=7), then normal sequence.
REQ-032 CR_Ena re-pulsed during GREEN and YELLOW -> ignored, single HW_Ena; CR_Ena=1 on HW_Ena cycle -> green next cycle.
REQ-033 rst asserted in YELLOW -> CR_LED=001, busy=0 immediately; no HW_Ena after release.
